// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned DefaultAddrW = 5;
  localparam int unsigned DefaultDataW = 32;
  localparam logic [31:0] DefaultHaltWord = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM, output-stage and redirect signals between the fetch sequencer and its neighbours.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
);

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_instr;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;

  modport master (
    output rom_addr,
    input  rom_instr,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready,
    input  redir_valid,
    input  redir_pc
  );

  modport slave (
    input  rom_addr,
    output rom_instr,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready,
    output redir_valid,
    output redir_pc
  );

endinterface

// File: rtl/fetch_counter.sv
// Saturating 16-bit counter of completed output handshakes.
module fetch_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, registers fetched words into a valid/ready stage.
// Optional handshake counter output fetch_cnt is built when FETCH_CNT_EN is defined.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DefaultAddrW,
  parameter int unsigned       DATA_W    = DefaultDataW,
  parameter int unsigned       RESET_PC  = 0,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DefaultHaltWord)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  fetch_sequencer_if.master bus,
  output logic              busy,
  output logic              halted
`ifdef FETCH_CNT_EN
  ,
  output logic [15:0]       fetch_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [DATA_W-1:0] out_instr_q, out_instr_d;
  logic              out_valid_q, out_valid_d;
  logic              load;

  // The output stage may take a new word when empty or when its current word leaves.
  assign load = (state_q == StFetch) && (!out_valid_q || bus.out_ready);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = ResetPc;
        end
      end
      StFetch: begin
        if (bus.redir_valid) begin
          pc_d        = bus.redir_pc;
          out_valid_d = 1'b0;
        end else if (load) begin
          if (bus.rom_instr == HALT_WORD) begin
            out_valid_d = 1'b0;
            state_d     = StHalt;
          end else begin
            out_instr_d = bus.rom_instr;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + ADDR_W'(1);
          end
        end
      end
      StHalt: begin
        if (start) begin
          state_d     = StFetch;
          pc_d        = ResetPc;
          out_valid_d = 1'b0;
        end else if (bus.redir_valid) begin
          state_d = StFetch;
          pc_d    = bus.redir_pc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= ResetPc;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.rom_addr  = pc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign busy          = (state_q == StFetch);
  assign halted        = (state_q == StHalt);

`ifdef FETCH_CNT_EN
  logic hs, start_ok;

  assign hs       = out_valid_q && bus.out_ready;
  assign start_ok = start && (state_q != StFetch);

  fetch_counter u_fetch_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .inc   (hs),
    .cnt   (fetch_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios plus randomized traffic against a behavioural fetch model.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam logic [31:0] Halt = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, halted;
`ifdef FETCH_CNT_EN
  logic [15:0] fetch_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rom [32];
  logic [31:0] prog [6];

  fetch_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  assign bus.rom_instr = rom[bus.rom_addr];

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .halted    (halted)
`ifdef FETCH_CNT_EN
    ,
    .fetch_cnt (fetch_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cnt(input string tag, input int exp);
`ifdef FETCH_CNT_EN
    check_eq(tag, 32'(fetch_cnt), 32'(exp));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_program();
    for (int i = 0; i < 32; i++) rom[i] = 32'h0;
    for (int i = 0; i < 6; i++) rom[i] = prog[i];
    rom[6] = Halt;
  endtask

  task automatic randomize_rom(input bit allow_halt);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      if (w == Halt) w = 32'h1234_5678;
      if (allow_halt && ($urandom_range(0, 9) == 0)) w = Halt;
      rom[i] = w;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bus.out_ready = 1'b1;
    bus.redir_valid = 1'b0;
    bus.redir_pc = '0;
    #7;
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_pc(input int target, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (bus.out_valid && (32'(bus.out_pc) == 32'(target))) found = 1'b1;
      else step();
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_halt(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (halted) found = 1'b1;
      else step();
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_instr"}, bus.out_instr, 32'd0);
    check_eq({tag, "_pc"}, 32'(bus.out_pc), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_halted"}, 32'(halted), 32'd0);
    check_eq({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
    check_cnt({tag, "_cnt"}, 0);
  endtask

  // Behavioural model: what the consumer should see, derived from the fetch rules.
  bit          m_fetching, m_halted, m_valid;
  int          m_pc, m_wpc, m_cnt;
  logic [31:0] m_word;

  task automatic model_advance(input bit st, input bit rdy, input bit rv, input int rpc);
    bit taken;
    taken = m_valid && rdy;
    if (st && !m_fetching) m_cnt = 0;
    else if (taken && m_cnt < 16'hFFFF) m_cnt++;
    if (m_fetching) begin
      if (rv) begin
        m_pc = rpc;
        m_valid = 1'b0;
      end else if (!m_valid || rdy) begin
        if (rom[m_pc] == Halt) begin
          m_valid = 1'b0;
          m_fetching = 1'b0;
          m_halted = 1'b1;
        end else begin
          m_word = rom[m_pc];
          m_wpc = m_pc;
          m_valid = 1'b1;
          m_pc = (m_pc + 1) % 32;
        end
      end
    end else if (st) begin
      m_fetching = 1'b1;
      m_halted = 1'b0;
      m_pc = 0;
      m_valid = 1'b0;
    end else if (m_halted && rv) begin
      m_fetching = 1'b1;
      m_halted = 1'b0;
      m_pc = rpc;
    end
  endtask

  initial begin
    bit st, rdy, rv;
    int rpc;
    prog[0] = 32'h0000_0093;
    prog[1] = 32'h0100_0113;
    prog[2] = 32'h0640_0193;
    prog[3] = 32'h0080_0213;
    prog[4] = 32'h0020_82b3;
    prog[5] = 32'h0041_8333;
    load_program();
    bus.out_ready = 1'b1;
    bus.redir_valid = 1'b0;
    bus.redir_pc = '0;
    #2;
    check_reset_values("reset");
    #6;
    rst_n = 1'b1;
    step();

    // Program run to the halt word.
    pulse_start();
    check_eq("run_busy", 32'(busy), 32'd1);
    check_eq("run_first_bubble", 32'(bus.out_valid), 32'd0);
    step();
    for (int i = 0; i < 6; i++) begin
      check_eq("run_valid", 32'(bus.out_valid), 32'd1);
      check_eq("run_pc", 32'(bus.out_pc), 32'(i));
      check_eq("run_instr", bus.out_instr, prog[i]);
      step();
    end
    check_eq("run_halted", 32'(halted), 32'd1);
    check_eq("run_busy_off", 32'(busy), 32'd0);
    check_eq("run_valid_off", 32'(bus.out_valid), 32'd0);
    check_cnt("run_cnt", 6);

    // Restart from HALT with start, then resume from HALT with a redirect.
    pulse_start();
    check_eq("restart_busy", 32'(busy), 32'd1);
    check_eq("restart_halted", 32'(halted), 32'd0);
    check_cnt("restart_cnt_clr", 0);
    step();
    check_eq("restart_valid", 32'(bus.out_valid), 32'd1);
    check_eq("restart_pc", 32'(bus.out_pc), 32'd0);
    wait_halt("restart_halt_again");
    bus.redir_valid = 1'b1;
    bus.redir_pc = 5'd3;
    step();
    bus.redir_valid = 1'b0;
    check_eq("resume_busy", 32'(busy), 32'd1);
    check_eq("resume_bubble", 32'(bus.out_valid), 32'd0);
    step();
    check_eq("resume_pc", 32'(bus.out_pc), 32'd3);
    check_eq("resume_instr", bus.out_instr, prog[3]);

    // Backpressure holds the output stage and the PC.
    do_reset();
    pulse_start();
    wait_pc(2, "bp_reach_pc2");
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("bp_pc_hold", 32'(bus.out_pc), 32'd2);
      check_eq("bp_instr_hold", bus.out_instr, prog[2]);
      check_eq("bp_rom_addr", 32'(bus.rom_addr), 32'd3);
    end
    bus.out_ready = 1'b1;
    step();
    check_eq("bp_release_pc", 32'(bus.out_pc), 32'd3);

    // Redirect with a one-cycle bubble; the coincident handshake still counts.
    do_reset();
    pulse_start();
    wait_pc(1, "redir_reach_pc1");
    bus.redir_valid = 1'b1;
    bus.redir_pc = 5'd4;
    step();
    bus.redir_valid = 1'b0;
    check_eq("redir_bubble", 32'(bus.out_valid), 32'd0);
    step();
    check_eq("redir_valid", 32'(bus.out_valid), 32'd1);
    check_eq("redir_pc", 32'(bus.out_pc), 32'd4);
    check_eq("redir_instr", bus.out_instr, prog[4]);
    wait_halt("redir_halt");
    check_cnt("redir_cnt", 4);

    // PC wraps from 31 to 0.
    randomize_rom(1'b0);
    do_reset();
    pulse_start();
    bus.redir_valid = 1'b1;
    bus.redir_pc = 5'd30;
    step();
    bus.redir_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq("wrap_pc", 32'(bus.out_pc), 32'((30 + i) % 32));
      check_eq("wrap_instr", bus.out_instr, rom[(30 + i) % 32]);
      step();
    end

    // Asynchronous reset mid-run.
    load_program();
    do_reset();
    pulse_start();
    wait_pc(3, "rst_reach_pc3");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    step();
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("rst_idle_busy", 32'(busy), 32'd0);
      check_eq("rst_idle_valid", 32'(bus.out_valid), 32'd0);
    end
    pulse_start();
    step();
    check_eq("rst_restart_pc", 32'(bus.out_pc), 32'd0);
    check_eq("rst_restart_valid", 32'(bus.out_valid), 32'd1);

    // Randomized traffic against the model.
    randomize_rom(1'b1);
    do_reset();
    m_fetching = 1'b0;
    m_halted = 1'b0;
    m_valid = 1'b0;
    m_pc = 0;
    m_wpc = 0;
    m_cnt = 0;
    m_word = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      check_eq("rnd_valid", 32'(bus.out_valid), 32'(m_valid));
      check_eq("rnd_pc", 32'(bus.out_pc), 32'(m_wpc));
      check_eq("rnd_instr", bus.out_instr, m_word);
      check_eq("rnd_busy", 32'(busy), 32'(m_fetching));
      check_eq("rnd_halted", 32'(halted), 32'(m_halted));
      check_eq("rnd_rom_addr", 32'(bus.rom_addr), 32'(m_pc));
      check_cnt("rnd_cnt", m_cnt);
      st  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = int'($urandom_range(0, 31));
      start = st;
      bus.out_ready = rdy;
      bus.redir_valid = rv;
      bus.redir_pc = AW'(rpc);
      model_advance(st, rdy, rv, rpc);
      step();
    end
    start = 1'b0;
    bus.redir_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
